// File: rtl/fsgn_pkg.sv
// fsgn_pkg: op encodings, slot states and NaN helper for the sign-injection arbiter
package fsgn_pkg;
  localparam logic [1:0] FSGN_J   = 2'b00;
  localparam logic [1:0] FSGN_JN  = 2'b01;
  localparam logic [1:0] FSGN_JX  = 2'b10;
  localparam logic [1:0] FSGN_RSV = 2'b11;
  typedef enum logic {EMPTY, FULL} slot_t;
  function automatic logic is_nan(input logic [31:0] v);
    return (&v[30:23]) & (|v[22:0]);
  endfunction
endpackage

// File: rtl/fsgn_arbiter_if.sv
// fsgn_arbiter_if: two requester handshakes plus the result slot handshake
interface fsgn_arbiter_if #(parameter int TAG_W = 5);
  logic             req0_valid, req0_ready;
  logic [1:0]       req0_op;
  logic [31:0]      req0_x1, req0_x2;
  logic [TAG_W-1:0] req0_tag;
  logic             req1_valid, req1_ready;
  logic [1:0]       req1_op;
  logic [31:0]      req1_x1, req1_x2;
  logic [TAG_W-1:0] req1_tag;
  logic             res_valid, res_ready;
  logic [31:0]      res_y;
  logic             res_exception;
  logic [TAG_W-1:0] res_tag;
  logic             res_src;
  modport master (
    output req0_valid, req0_op, req0_x1, req0_x2, req0_tag,
    output req1_valid, req1_op, req1_x1, req1_x2, req1_tag,
    input  req0_ready, req1_ready,
    input  res_valid, res_y, res_exception, res_tag, res_src,
    output res_ready
  );
  modport slave (
    input  req0_valid, req0_op, req0_x1, req0_x2, req0_tag,
    input  req1_valid, req1_op, req1_x1, req1_x2, req1_tag,
    output req0_ready, req1_ready,
    output res_valid, res_y, res_exception, res_tag, res_src,
    input  res_ready
  );
endinterface

// File: rtl/fsgn_core.sv
// fsgn_core: combinational fsgnj/fsgnjn/fsgnjx with NaN and illegal-op flag
module fsgn_core
  import fsgn_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic [31:0] y,
  output logic        exception
);
  always_comb begin
    y = {op == FSGN_J ? x2[31] : op == FSGN_JN ? ~x2[31] : op == FSGN_JX ? x1[31] ^ x2[31] : x1[31], x1[30:0]};
    exception = (op == FSGN_RSV) | is_nan(x1) | is_nan(x2);
  end
endmodule

// File: rtl/fsgn_arbiter.sv
// fsgn_arbiter: round-robin share of one sign-injection core feeding a one-entry result slot
module fsgn_arbiter
  import fsgn_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input logic clk,
  input logic rst,
  fsgn_arbiter_if.slave b
);
  slot_t            state, state_n;
  logic             ptr, sel, accept, can_accept, exc;
  logic [1:0]       op;
  logic [31:0]      x1, x2, y;
  logic [TAG_W-1:0] tag;
  always_comb begin
    can_accept = ~rst & ((state == EMPTY) | b.res_ready);
    sel = (b.req0_valid & b.req1_valid) ? ptr : b.req1_valid;
    accept = can_accept & (b.req0_valid | b.req1_valid);
    op = sel ? b.req1_op : b.req0_op;
    x1 = sel ? b.req1_x1 : b.req0_x1;
    x2 = sel ? b.req1_x2 : b.req0_x2;
    tag = sel ? b.req1_tag : b.req0_tag;
    state_n = accept ? FULL : (state == FULL & ~b.res_ready) ? FULL : EMPTY;
  end
  assign b.req0_ready = accept & ~sel;
  assign b.req1_ready = accept & sel;
  assign b.res_valid = state == FULL;
  fsgn_core u_core (.op(op), .x1(x1), .x2(x2), .y(y), .exception(exc));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      ptr <= 1'b0;
      b.res_y <= '0;
      b.res_exception <= 1'b0;
      b.res_tag <= '0;
      b.res_src <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        ptr <= ~sel;
        b.res_y <= y;
        b.res_exception <= exc;
        b.res_tag <= tag;
        b.res_src <= sel;
      end
    end
  end
endmodule

// File: tb/tb_fsgn_arbiter.sv
// tb_fsgn_arbiter: directed vectors for datapath, round-robin, backpressure and reset
module tb_fsgn_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  fsgn_arbiter_if #(.TAG_W(5)) bus ();
  fsgn_arbiter #(.TAG_W(5)) dut (.clk(clk), .rst(rst), .b(bus));
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  task automatic set_req(input logic k, input logic [1:0] op, input logic [31:0] x1, input logic [31:0] x2, input logic [4:0] tag);
    if (k) begin
      bus.req1_op = op; bus.req1_x1 = x1; bus.req1_x2 = x2; bus.req1_tag = tag;
    end else begin
      bus.req0_op = op; bus.req0_x1 = x1; bus.req0_x2 = x2; bus.req0_tag = tag;
    end
  endtask
  task automatic issue(input string name, input logic k, input logic [1:0] op, input logic [31:0] x1, input logic [31:0] x2,
                       input logic [4:0] tag, input logic [31:0] ey, input logic ee);
    set_req(k, op, x1, x2, tag);
    bus.req0_valid = ~k;
    bus.req1_valid = k;
    #1;
    chk({name, "_ready"}, {31'd0, k ? bus.req1_ready : bus.req0_ready}, 32'd1);
    chk({name, "_other_ready"}, {31'd0, k ? bus.req0_ready : bus.req1_ready}, 32'd0);
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk({name, "_valid"}, {31'd0, bus.res_valid}, 32'd1);
    chk({name, "_y"}, bus.res_y, ey);
    chk({name, "_exc"}, {31'd0, bus.res_exception}, {31'd0, ee});
    chk({name, "_tag"}, {27'd0, bus.res_tag}, {27'd0, tag});
    chk({name, "_src"}, {31'd0, bus.res_src}, {31'd0, k});
  endtask
  task automatic chk_zero_outputs(input string name);
    chk({name, "_valid"}, {31'd0, bus.res_valid}, 32'd0);
    chk({name, "_y"}, bus.res_y, 32'd0);
    chk({name, "_exc"}, {31'd0, bus.res_exception}, 32'd0);
    chk({name, "_tag"}, {27'd0, bus.res_tag}, 32'd0);
    chk({name, "_src"}, {31'd0, bus.res_src}, 32'd0);
  endtask
  initial begin
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b0;
    bus.res_ready = 1'b1;
    set_req(1'b0, 2'b00, 32'h3F800000, 32'hC0000000, 5'd1);
    set_req(1'b1, 2'b00, 32'h0, 32'h0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    chk_zero_outputs("rst");
    chk("rst_ready0", {31'd0, bus.req0_ready}, 32'd0);
    rst = 1'b0;
    bus.req0_valid = 1'b0;
    issue("fsgnj",     1'b0, 2'b00, 32'h3F800000, 32'hC0000000, 5'd5,  32'hBF800000, 1'b0);
    issue("fsgnjn",    1'b0, 2'b01, 32'h3F800000, 32'hC0000000, 5'd6,  32'h3F800000, 1'b0);
    issue("fsgnjx",    1'b1, 2'b10, 32'hBF800000, 32'hC0000000, 5'd7,  32'h3F800000, 1'b0);
    issue("rsv",       1'b0, 2'b11, 32'h40490FDB, 32'h80000000, 5'd8,  32'h40490FDB, 1'b1);
    issue("nan_x2",    1'b1, 2'b00, 32'h3F800000, 32'hFFC00000, 5'd9,  32'hBF800000, 1'b1);
    issue("inf_x1",    1'b0, 2'b00, 32'h7F800000, 32'h00000000, 5'd10, 32'h7F800000, 1'b0);
    issue("nan_x1",    1'b1, 2'b00, 32'h7FC00001, 32'h80000000, 5'd11, 32'hFFC00001, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_req(1'b0, 2'b00, 32'h3F800000, 32'hC0000000, 5'd1);
    set_req(1'b1, 2'b01, 32'h40000000, 32'h00000000, 5'd2);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_ready0", {31'd0, bus.req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_ready1", {31'd0, bus.req1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
      chk("rr_src", {31'd0, bus.res_src}, (i % 2 == 1) ? 32'd1 : 32'd0);
      chk("rr_y", bus.res_y, (i % 2 == 1) ? 32'hC0000000 : 32'hBF800000);
    end
    bus.res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_ready0", {31'd0, bus.req0_ready}, 32'd0);
      chk("bp_ready1", {31'd0, bus.req1_ready}, 32'd0);
      @(posedge clk);
      #1;
      chk("bp_valid", {31'd0, bus.res_valid}, 32'd1);
      chk("bp_src", {31'd0, bus.res_src}, 32'd1);
      chk("bp_tag", {27'd0, bus.res_tag}, 32'd2);
      chk("bp_y", bus.res_y, 32'hC0000000);
    end
    bus.res_ready = 1'b1;
    #1;
    chk("rel_ready0", {31'd0, bus.req0_ready}, 32'd1);
    chk("rel_ready1", {31'd0, bus.req1_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("rel_src", {31'd0, bus.res_src}, 32'd0);
    chk("rel_tag", {27'd0, bus.res_tag}, 32'd1);
    chk("rel_y", bus.res_y, 32'hBF800000);
    rst = 1'b1;
    #1;
    chk("rstf_ready0", {31'd0, bus.req0_ready}, 32'd0);
    chk("rstf_ready1", {31'd0, bus.req1_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk_zero_outputs("rstf");
    rst = 1'b0;
    #1;
    chk("post_ready0", {31'd0, bus.req0_ready}, 32'd1);
    chk("post_ready1", {31'd0, bus.req1_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("post_valid", {31'd0, bus.res_valid}, 32'd1);
    chk("post_src", {31'd0, bus.res_src}, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fsgn_arbiter.md
# fsgn_arbiter

Shares one sign-injection datapath (fsgnj / fsgnjn / fsgnjx) between two issue requesters. Each requester presents an operation through a valid/ready handshake. A round-robin arbiter grants one request per cycle. The result is registered in a single-entry output slot with its own valid/ready handshake, and the slot feeds the FPU writeback path.

## Interface
- TAG_W, default 5: width of the destination tag carried with each request.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 presents an operation.
- req0_ready  out  1  requester 0's operation is accepted this cycle.
- req0_op  in  2  operation: 00 fsgnj, 01 fsgnjn, 10 fsgnjx, 11 reserved.
- req0_x1, req0_x2  in  32  IEEE-754 single-precision operands.
- req0_tag  in  TAG_W  destination tag.
- req1_valid, req1_ready, req1_op, req1_x1, req1_x2, req1_tag: same as requester 0, for requester 1.
- res_valid  out  1  the output slot holds a result.
- res_ready  in  1  the consumer takes the result this cycle.
- res_y  out  32  result value.
- res_exception  out  1  NaN-input or illegal-op flag.
- res_tag  out  TAG_W  tag of the result.
- res_src  out  1  index of the requester that issued the result.

## Operation
- Output slot FSM has two states.
  - EMPTY (res_valid=0).
  - FULL (res_valid=1).
  - Transitions:
    - EMPTY→FULL on accept.
    - FULL→EMPTY when res_ready=1 and no accept occurs.
    - FULL→FULL when res_ready=1 with a simultaneous accept; the slot is overwritten with the new result.
    - FULL→FULL when res_ready=0; all res_* outputs are held stable.
- can_accept = EMPTY | res_ready.
- Arbitration uses a 1-bit priority pointer, ptr.
  - If both requesters are valid, the requester equal to ptr is granted.
  - Otherwise the single valid requester is granted.
  - reqN_ready = grantN & can_accept. At most one ready is high per cycle.
  - reqN_ready may depend combinationally on reqN_valid.
  - After an accept from requester k, ptr ← ~k. Without an accept, ptr is unchanged.
  - With both requesters valid continuously, grants strictly alternate, so neither requester starves.
- Datapath. The result takes exponent and mantissa from x1 unchanged; the sign bit depends on the op:
  - fsgnj: sign(y) = sign(x2).
  - fsgnjn: sign(y) = ~sign(x2).
  - fsgnjx: sign(y) = sign(x1) ^ sign(x2).
  - reserved op 11: y = x1 and exception = 1.
- Exception: set when x1 or x2 is a NaN (exponent 255 and mantissa ≠ 0). Infinities do not set it.
  - The sign is injected onto NaN x1 operands as well; the payload is preserved.
- Reset:
  - res_valid=0; res_y, res_tag, res_exception and res_src are 0; ptr=0; FSM=EMPTY.
  - Reset during FULL discards the held result.
  - reqN_ready is 0 while rst=1.

## Timing
- Latency: an operation accepted in cycle n appears with res_valid=1 in cycle n+1.
- Throughput: 1 operation per cycle while res_ready=1.
- The datapath is combinational between the granted request and the slot register. No other pipeline stage exists.
- No combinational path runs from res_ready to any res_* output. res_ready feeds only can_accept.

## Structure
- Package fsgn_pkg holds:
  - op constants FSGN_J=2'b00, FSGN_JN=2'b01, FSGN_JX=2'b10, FSGN_RSV=2'b11;
  - function is_nan(logic [31:0]).
- Sub-module fsgn_core: purely combinational.
  - Inputs: op, x1, x2.
  - Outputs: y, exception.
  - Instantiated once, fed by the grant mux.
- fsgn_arbiter contains the arbiter, ptr, slot FSM and output registers.

## Test plan
- req0 fsgnj, x1=0x3F800000, x2=0xC0000000, res_ready=1 → next cycle res_valid=1, res_y=0xBF800000, res_exception=0, res_src=0, tag echoed.
- fsgnjn with the same operands → 0x3F800000. fsgnjx with x1=0xBF800000, x2=0xC0000000 → 0x3F800000. op 11 with x1=0x40490FDB → y=0x40490FDB, exception=1.
- fsgnj with x1=0x3F800000, x2=0xFFC00000 → y=0xBF800000, exception=1. With x1=0x7F800000, x2=0x00000000 → y=0x7F800000, exception=0.
- Both requesters valid every cycle, res_ready=1, from reset → res_src sequence 0,1,0,1,…. Each req_ready is high on alternate cycles.
- Backpressure: both valid, res_ready=0 with the slot FULL.
  - Both readys stay 0 and res_* is stable for 5 cycles.
  - The cycle res_ready rises, one request is accepted; the next cycle shows the new result.
- Assert rst while FULL → next cycle res_valid=0 and all outputs 0. With both requesters valid, the first grant goes to req0.
